// File: rtl/byte_reg_write_sched.sv
`default_nettype none
// ============================================================================
// byte_reg_write_sched : arbitrates two masked 32-bit word writers and
// serializes each accepted word into ascending-lane single-byte writes.
// Option macro: BYTE_SCHED_FIXED_PRIO_EN (req1 always wins a tie).
// Revision: 1.0
// ============================================================================
module byte_reg_write_sched #(
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [31:0]           req0_data,
  input  logic [3:0]            req0_mask,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [31:0]           req1_data,
  input  logic [3:0]            req1_mask,
  output logic                  reg_we,
  output logic [ADDR_WIDTH-1:0] reg_addr,
  output logic [1:0]            reg_byte_sel,
  output logic [7:0]            reg_byte_in,
  output logic                  busy,
  output logic                  done,
  output logic                  done_id
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } state_t;

  state_t          r_state;
  logic [31:0]     r_data;
  logic [3:0]      r_rem;

  logic                  w_grant;
  logic                  w_idle;
  logic                  w_accept;
  logic [ADDR_WIDTH-1:0] w_req_addr;
  logic [31:0]           w_req_data;
  logic [3:0]            w_req_mask;
  logic [3:0]            w_next_rem;

  function automatic logic [1:0] f_low_lane(input logic [3:0] m);
    if (m[0])      return 2'd0;
    else if (m[1]) return 2'd1;
    else if (m[2]) return 2'd2;
    else           return 2'd3;
  endfunction

  function automatic logic [7:0] f_lane_byte(input logic [31:0] d, input logic [1:0] lane);
    case (lane)
      2'd0:    return d[7:0];
      2'd1:    return d[15:8];
      2'd2:    return d[23:16];
      default: return d[31:24];
    endcase
  endfunction

  function automatic logic f_at_most_one(input logic [3:0] m);
    return (m & (m - 4'd1)) == 4'd0;
  endfunction

`ifdef BYTE_SCHED_FIXED_PRIO_EN
  assign w_grant = req1_valid;
`else
  logic r_last_grant;

  // On a tie the requester that did not win last time is granted.
  always_comb begin
    w_grant = req1_valid;
    if (req0_valid && req1_valid) w_grant = ~r_last_grant;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           r_last_grant <= 1'b1;
    else if (w_accept) r_last_grant <= w_grant;
  end
`endif

  // Ready is masked while rst is high so nothing is offered during reset.
  assign w_idle     = (r_state == ST_IDLE) && !rst;
  assign req0_ready = w_idle && req0_valid && !w_grant;
  assign req1_ready = w_idle && req1_valid && w_grant;
  assign w_accept   = req0_ready || req1_ready;

  assign w_req_addr = w_grant ? req1_addr : req0_addr;
  assign w_req_data = w_grant ? req1_data : req0_data;
  assign w_req_mask = w_grant ? req1_mask : req0_mask;
  assign w_next_rem = r_rem & (r_rem - 4'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_data       <= '0;
      r_rem        <= '0;
      reg_we       <= 1'b0;
      reg_addr     <= '0;
      reg_byte_sel <= 2'd0;
      reg_byte_in  <= 8'd0;
      busy         <= 1'b0;
      done         <= 1'b0;
      done_id      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            // First byte is prepared here so it is on the port in the first WRITE cycle.
            r_state      <= ST_WRITE;
            r_data       <= w_req_data;
            r_rem        <= w_req_mask;
            reg_addr     <= w_req_addr;
            busy         <= 1'b1;
            reg_we       <= |w_req_mask;
            reg_byte_sel <= f_low_lane(w_req_mask);
            reg_byte_in  <= f_lane_byte(w_req_data, f_low_lane(w_req_mask));
            done         <= f_at_most_one(w_req_mask);
            done_id      <= w_grant;
          end
        end
        ST_WRITE: begin
          if (f_at_most_one(r_rem)) begin
            r_state <= ST_IDLE;
            r_rem   <= '0;
            busy    <= 1'b0;
            reg_we  <= 1'b0;
            done    <= 1'b0;
          end else begin
            r_rem        <= w_next_rem;
            reg_we       <= 1'b1;
            reg_byte_sel <= f_low_lane(w_next_rem);
            reg_byte_in  <= f_lane_byte(r_data, f_low_lane(w_next_rem));
            done         <= f_at_most_one(w_next_rem);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_byte_reg_write_sched.sv
`default_nettype none
// tb_byte_reg_write_sched : directed and randomized checks against a
// transaction-level model (lane lists per accepted word, round-robin grant).
module tb_byte_reg_write_sched;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0_valid, req0_ready, req1_valid, req1_ready;
  logic [AW-1:0] req0_addr, req1_addr;
  logic [31:0]   req0_data, req1_data;
  logic [3:0]    req0_mask, req1_mask;
  logic          reg_we, busy, done, done_id;
  logic [AW-1:0] reg_addr;
  logic [1:0]    reg_byte_sel;
  logic [7:0]    reg_byte_in;

  byte_reg_write_sched #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr),
    .req0_data(req0_data), .req0_mask(req0_mask),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr),
    .req1_data(req1_data), .req1_mask(req1_mask),
    .reg_we(reg_we), .reg_addr(reg_addr), .reg_byte_sel(reg_byte_sel),
    .reg_byte_in(reg_byte_in), .busy(busy), .done(done), .done_id(done_id)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    bit          we;
    bit [1:0]    sel;
    bit [7:0]    b;
    bit [AW-1:0] addr;
    bit          done;
    bit          id;
  } rec_t;

  rec_t exp_q[$];
  int   grants[$];
  bit   last_grant;
  int   n_pass = 0;
  int   n_total = 0;
  int   n_we = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic int model_grant(input bit v0, input bit v1);
`ifdef BYTE_SCHED_FIXED_PRIO_EN
    if (v1) return 1;
    if (v0) return 0;
    return -1;
`else
    if (v0 && v1) return last_grant ? 0 : 1;
    if (v1) return 1;
    if (v0) return 0;
    return -1;
`endif
  endfunction

  // Expected byte writes of one word: set lanes in ascending order, done on the last.
  task automatic push_txn(input bit id, input bit [AW-1:0] a, input bit [31:0] d, input bit [3:0] m);
    int   lanes[$];
    rec_t r;
    for (int i = 0; i < 4; i++) if (m[i]) lanes.push_back(i);
    r = '0;
    r.addr = a;
    r.id   = id;
    if (lanes.size() == 0) begin
      r.done = 1'b1;
      exp_q.push_back(r);
    end else begin
      foreach (lanes[k]) begin
        r.we   = 1'b1;
        r.sel  = 2'(lanes[k]);
        r.b    = 8'(d >> (8 * lanes[k]));
        r.done = (k == lanes.size() - 1);
        exp_q.push_back(r);
      end
    end
  endtask

  task automatic drive(input bit id, input bit v, input bit [AW-1:0] a, input bit [31:0] d, input bit [3:0] m);
    if (id == 1'b0) begin
      req0_valid = v; req0_addr = a; req0_data = d; req0_mask = m;
    end else begin
      req1_valid = v; req1_addr = a; req1_data = d; req1_mask = m;
    end
  endtask

  // One clock cycle: compare at the falling edge, advance the model, return the accepted id.
  task automatic step(input string tag, output int acc);
    rec_t r;
    int   g;
    acc = -1;
    @(negedge clk);
    if (exp_q.size() != 0) begin
      r = exp_q.pop_front();
      chk({tag, ".busy"}, 32'(busy), 32'd1);
      chk({tag, ".rdy_wr"}, 32'({req1_ready, req0_ready}), 32'd0);
      chk({tag, ".we"}, 32'(reg_we), 32'(r.we));
      chk({tag, ".done"}, 32'(done), 32'(r.done));
      if (reg_we) n_we++;
      if (r.we) begin
        chk({tag, ".sel"}, 32'(reg_byte_sel), 32'(r.sel));
        chk({tag, ".byte"}, 32'(reg_byte_in), 32'(r.b));
        chk({tag, ".addr"}, 32'(reg_addr), 32'(r.addr));
      end
      if (r.done) chk({tag, ".done_id"}, 32'(done_id), 32'(r.id));
    end else begin
      g = model_grant(req0_valid, req1_valid);
      chk({tag, ".idle_busy"}, 32'(busy), 32'd0);
      chk({tag, ".idle_we"}, 32'(reg_we), 32'd0);
      chk({tag, ".idle_done"}, 32'(done), 32'd0);
      chk({tag, ".ready0"}, 32'(req0_ready), 32'(g == 0));
      chk({tag, ".ready1"}, 32'(req1_ready), 32'(g == 1));
      if (g == 0) push_txn(1'b0, req0_addr, req0_data, req0_mask);
      if (g == 1) push_txn(1'b1, req1_addr, req1_data, req1_mask);
      if (g >= 0) begin
        last_grant = g[0];
        grants.push_back(g);
        acc = g;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic run_req(input bit id, input bit [AW-1:0] a, input bit [31:0] d, input bit [3:0] m, input string tag);
    int acc = -1;
    int dummy;
    drive(id, 1'b1, a, d, m);
    for (int n = 0; n < 8 && acc < 0; n++) step(tag, acc);
    chk({tag, ".accept"}, 32'(acc), 32'(id));
    drive(id, 1'b0, a, d, m);
    n_we = 0;
    for (int n = 0; n < 8 && exp_q.size() != 0; n++) step(tag, dummy);
    chk({tag, ".drain"}, 32'(exp_q.size()), 32'd0);
    chk({tag, ".nwe"}, 32'(n_we), 32'($countones(m)));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exp_q.delete();
    grants.delete();
    last_grant = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    int acc;
    int obs;
    rst = 1'b1;
    last_grant = 1'b1;
    drive(1'b0, 1'b0, '0, '0, '0);
    drive(1'b1, 1'b0, '0, '0, '0);
    @(posedge clk); #1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    chk("rst.we", 32'(reg_we), 32'd0);
    chk("rst.addr", 32'(reg_addr), 32'd0);
    chk("rst.sel", 32'(reg_byte_sel), 32'd0);
    chk("rst.byte", 32'(reg_byte_in), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.done_id", 32'(done_id), 32'd0);
    chk("rst.ready", 32'({req1_ready, req0_ready}), 32'd0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;

    run_req(1'b0, 4'd3, 32'hA1B2C3D4, 4'b1111, "full");
    run_req(1'b1, 4'd5, 32'h11223344, 4'b1010, "sparse");
    run_req(1'b0, 4'd7, 32'hDEADBEEF, 4'b0000, "nomask");

    // Both requesters continuously valid from reset with single-byte masks.
    do_reset();
    drive(1'b0, 1'b1, 4'd1, 32'h000000A0, 4'b0001);
    drive(1'b1, 1'b1, 4'd2, 32'h000000B0, 4'b0001);
    for (int n = 0; n < 40 && grants.size() < 4; n++) begin
      step("tie", acc);
      if (acc >= 0) drive(acc[0], 1'b1, AW'($urandom_range(0, 15)), $urandom, 4'b0001);
    end
    for (int i = 0; i < 4; i++) begin
      obs = (i < grants.size()) ? grants[i] : 99;
`ifdef BYTE_SCHED_FIXED_PRIO_EN
      chk("tie.grant", 32'(obs), 32'd1);
`else
      chk("tie.grant", 32'(obs), 32'(i % 2));
`endif
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    for (int n = 0; n < 8 && exp_q.size() != 0; n++) step("tie", acc);

    // Reset in the middle of a four-byte write, after the second byte.
    acc = -1;
    drive(1'b0, 1'b1, 4'd9, 32'h55667788, 4'b1111);
    for (int n = 0; n < 8 && acc < 0; n++) step("rstmid", acc);
    req0_valid = 1'b0;
    step("rstmid", acc);
    step("rstmid", acc);
    rst = 1'b1;
    #1;
    chk("rstmid.we", 32'(reg_we), 32'd0);
    chk("rstmid.busy", 32'(busy), 32'd0);
    chk("rstmid.done", 32'(done), 32'd0);
    chk("rstmid.addr", 32'(reg_addr), 32'd0);
    exp_q.delete();
    last_grant = 1'b1;
    drive(1'b0, 1'b1, 4'd2, 32'hCAFEF00D, 4'b0110);
    @(negedge clk);
    chk("rstmid.ready0", 32'(req0_ready), 32'd0);
    chk("rstmid.done_hold", 32'(done), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    run_req(1'b0, 4'd2, 32'hCAFEF00D, 4'b0110, "rearm");

    // Random traffic: a request is held until accepted, then replaced or dropped.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      step("rand", acc);
      if (acc == 0 || !req0_valid)
        drive(1'b0, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), $urandom, 4'($urandom_range(0, 15)));
      if (acc == 1 || !req1_valid)
        drive(1'b1, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), $urandom, 4'($urandom_range(0, 15)));
    end
    if (exp_q.size() == 0) begin
      req0_valid = 1'b0;
      req1_valid = 1'b0;
    end
    for (int n = 0; n < 12 && exp_q.size() != 0; n++) begin
      step("rand", acc);
      if (acc == 0) req0_valid = 1'b0;
      if (acc == 1) req1_valid = 1'b0;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    for (int n = 0; n < 12 && exp_q.size() != 0; n++) step("rand", acc);
    chk("rand.drain", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/byte_reg_write_sched.md
# byte_reg_write_sched

Write scheduler and arbiter for the byte-wide register write port used by the controller's byte-enable registers. It accepts 32-bit masked word writes from two requesters: requester 0 is the host bus interface, and requester 1 is the SD command/data engine updating status and response registers. It arbitrates between them and serializes each accepted word into single-byte writes (write enable, byte select, byte value, register address). Those writes fan out to the register bank.

## Interface
Parameters:
- ADDR_WIDTH, 4, width of register address (selects one byte-enable register in the bank)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- req0_valid  in  1  host write request
- req0_ready  out  1  host request accepted this cycle when high together with req0_valid
- req0_addr  in  ADDR_WIDTH  target register
- req0_data  in  32  word data; byte i = bits [8i+7:8i]
- req0_mask  in  4  byte mask; bit i set = write byte i
- req1_valid, req1_ready, req1_addr, req1_data, req1_mask: same as req0_*, for the SD engine
- reg_we  out  1  byte write strobe to register bank
- reg_addr  out  ADDR_WIDTH  target register of current byte write
- reg_byte_sel  out  2  byte lane of current write
- reg_byte_in  out  8  byte value of current write
- busy  out  1  high while in WRITE
- done  out  1  one-cycle pulse on the final cycle of an operation
- done_id  out  1  requester index of the operation signalled by done

## Operation
- States: IDLE, WRITE. Reset state is IDLE.
- IDLE behaviour:
  - Grant selection is combinational from the valid inputs and the last_grant register.
  - Exactly one reqN_ready is high, and only if the granted reqN_valid is high.
  - Ready may depend combinationally on both valids.
  - Requesters must hold valid, addr, data and mask stable until ready.
- Arbitration (default): round-robin.
  - If only one valid is high, it is granted.
  - If both are high, the requester that is not last_grant is granted.
  - last_grant resets to 1, so req0 wins the first tie.
- Acceptance edge (valid & ready):
  - Latch addr, data, mask into rem_mask, and latch id.
  - Update last_grant.
  - Move to WRITE.
- WRITE behaviour:
  - Each cycle, select the lowest set bit i of rem_mask.
  - Drive reg_we=1, reg_byte_sel=i, reg_byte_in=data byte i, reg_addr=latched addr.
  - Clear bit i at the clock edge.
  - Bytes are issued strictly in ascending lane order; unmasked lanes are skipped with no idle cycle.
- done=1 and done_id=latched id in the WRITE cycle where rem_mask has at most one bit set; next state is IDLE.
- Mask 4'b0000: the request is still accepted. WRITE lasts one cycle with reg_we=0 and done=1.
- Both ready outputs are 0 throughout WRITE. Valids arriving during WRITE wait.
- Outputs in IDLE: reg_we=0, done=0, busy=0. reg_addr, reg_byte_sel and reg_byte_in are don't-care when reg_we=0 but must not be X.

## Timing
- Reset values: reg_we=0, reg_addr=0, reg_byte_sel=0, reg_byte_in=0, busy=0, done=0, done_id=0, both ready=0 (until reset deasserts and a valid arrives).
- Acceptance at edge N: the first byte write is visible in the cycle after N. A mask with k set bits (k≥1) occupies exactly k WRITE cycles; k=0 occupies 1 cycle.
- After done there is one IDLE cycle before the next write can start. Peak throughput is 4 bytes per 5 cycles.
- Reset asserted mid-WRITE:
  - All outputs go to reset values immediately (asynchronously).
  - The operation is discarded and no done is issued.
  - Bytes already written remain written.
- Simultaneous valid on both requesters in IDLE: exactly one is accepted. The other is accepted in the next IDLE cycle after done, if still valid.

## Configuration
- BYTE_SCHED_FIXED_PRIO_EN:
  - Defined: fixed priority. req1 (SD engine) always wins when both are valid. last_grant is not implemented, and req0 may starve.
  - Undefined (default): round-robin as described above.

## Test plan
- Reset mid-WRITE with mask 4'b1111, rst after the second byte -> reg_we drops immediately, no done pulse, state is IDLE on release, req0 re-accepted normally.
- req0 addr=3, data=32'hA1B2C3D4, mask=4'b1111 -> four consecutive reg_we cycles with (sel,byte)=(0,D4),(1,C3),(2,B2),(3,A1), reg_addr=3, done with done_id=0 on the 4th cycle.
- req1 mask=4'b1010, data=32'h11223344 -> exactly two writes, (1,33) then (3,11), in back-to-back cycles; done on the second.
- req0 mask=4'b0000 -> accepted, one busy cycle, reg_we never asserted, done=1 with done_id=0.
- Both valid continuously from reset, each mask=4'b0001 -> grants alternate 0,1,0,1. With BYTE_SCHED_FIXED_PRIO_EN defined, every grant goes to req1.
